data_mem_responder: RTL and testbench

//   Memory-side responder for the core's data port (mem_write / alu_result / write_data / read_data).

---
 rtl/data_mem_responder.sv | 136 +++++++++++++
 tb/tb_data_mem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Word-addressed data RAM with programmable wait states and a
//               req/ready handshake for the core's load/store port.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,            // legal range 1..15
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000 // must be word aligned
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        err
);

    localparam int         c_idx_w    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] c_cnt_init = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_enter_resp;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_write;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] mem [DEPTH_WORDS];

    // With LATENCY==1 the array is accessed on the accepting edge itself, so
    // the live inputs are used in IDLE and the latched copy everywhere else.
    logic        w_sel_live;
    logic [31:0] w_acc_addr;
    logic [31:0] w_acc_wdata;
    logic        w_acc_write;
    logic [31:0] w_off;
    logic        w_err;
    logic [c_idx_w-1:0] w_idx;

    assign w_sel_live  = (r_state == c_st_idle);
    assign w_acc_addr  = w_sel_live ? addr       : r_addr;
    assign w_acc_wdata = w_sel_live ? write_data : r_wdata;
    assign w_acc_write = w_sel_live ? mem_write  : r_write;

    // The below-base test keeps a wrapped subtraction from looking in range.
    assign w_off = w_acc_addr - BASE_ADDR;
    assign w_err = (w_acc_addr[1:0] != 2'b00) ||
                   (w_acc_addr < BASE_ADDR) ||
                   ((w_off >> 2) >= 32'(DEPTH_WORDS));
    assign w_idx = w_off[c_idx_w+1:2];

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (mem_req) begin
                    if (LATENCY == 1) begin
                        w_state_nxt  = c_st_resp;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = c_st_wait;
                        w_cnt_nxt   = c_cnt_init;
                    end
                end
            end
            c_st_wait: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt  = c_st_resp;
                    w_enter_resp = 1'b1;
                end
            end
            c_st_resp: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_write <= 1'b0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == c_st_idle && mem_req) begin
                r_addr  <= addr;
                r_wdata <= write_data;
                r_write <= mem_write;
            end
            r_err <= w_enter_resp && w_err;
            if (w_enter_resp && (w_err || !w_acc_write)) begin
                r_rdata <= w_err ? 32'd0 : mem[w_idx];
            end
        end
    end

    // Array contents survive reset; reset only blocks a commit on its edge.
    always_ff @(posedge clk) begin
        if (!reset && w_enter_resp && w_acc_write && !w_err) begin
            mem[w_idx] <= w_acc_wdata;
        end
    end

    assign ready     = (r_state == c_st_resp);
    assign err       = r_err;
    assign read_data = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed bench for data_mem_responder across several latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int N = 4;

    function automatic int lat_of(int k);
        case (k)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            default: return 15;
        endcase
    endfunction

    function automatic logic [31:0] base_of(int k);
        return (k == 2) ? 32'h0000_0100 : 32'h0000_0000;
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic        req   [N];
    logic        wr    [N];
    logic [31:0] addr  [N];
    logic [31:0] wdata [N];
    logic [31:0] rdata [N];
    logic        rdy   [N];
    logic        err   [N];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            data_mem_responder #(
                .DEPTH_WORDS(256),
                .LATENCY    (lat_of(g)),
                .BASE_ADDR  (base_of(g))
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .mem_req   (req[g]),
                .mem_write (wr[g]),
                .addr      (addr[g]),
                .write_data(wdata[g]),
                .read_data (rdata[g]),
                .ready     (rdy[g]),
                .err       (err[g])
            );
        end
    endgenerate

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] ref_mem [N][256];
    logic [31:0] exp_rd  [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access: drive in an IDLE cycle, scramble inputs while waiting,
    // measure latency and compare against the model.
    task automatic txn(input int k, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit exp_err);
        int          n;
        bit          seen;
        logic [31:0] idx;
        @(negedge clk);
        req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d;
        @(posedge clk);
        @(negedge clk);
        req[k] = 1'b0; wr[k] = ~w; addr[k] = 32'hFFFF_FFF0; wdata[k] = ~d;
        n = 1;
        seen = 1'b0;
        while (!seen && n <= 40) begin
            if (rdy[k]) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check($sformatf("lat[%0d]", k), 32'(n), 32'(lat_of(k)));
        if (exp_err) begin
            exp_rd[k] = 32'd0;
        end else begin
            idx = (a - base_of(k)) >> 2;
            if (w) ref_mem[k][idx[7:0]] = d;
            else   exp_rd[k] = ref_mem[k][idx[7:0]];
        end
        check($sformatf("err[%0d]@%h", k, a), {31'd0, err[k]}, {31'd0, exp_err});
        check($sformatf("rdata[%0d]@%h", k, a), rdata[k], exp_rd[k]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int cyc;
        int last;
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            req[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0;
            exp_rd[k] = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("reset ready", {31'd0, rdy[k]}, 32'd0);
            check("reset err", {31'd0, err[k]}, 32'd0);
            check("reset rdata", rdata[k], 32'd0);
        end
        reset = 1'b0;

        // Basic store/load, store response leaves read_data alone
        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 1'b0);
        // Load right after store, one IDLE gap
        txn(0, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
        txn(0, 1'b0, 32'h20, 32'h0, 1'b0);
        // Error accesses leave array untouched; out-of-range must not wrap to word 0
        txn(0, 1'b1, 32'h0, 32'h0BAD_0000, 1'b0);
        txn(0, 1'b0, 32'h13, 32'h0, 1'b1);
        txn(0, 1'b1, 32'h400, 32'hFFFF_0000, 1'b1);
        txn(0, 1'b1, 32'h11, 32'hFFFF_1111, 1'b1);
        txn(0, 1'b0, 32'h0, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 1'b0);

        // mem_req held high: one accept every LATENCY+1 cycles
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h80; wdata[0] = 32'hC0DE_0000;
        cnt = 0; cyc = 0; last = 0;
        while (cnt < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (rdy[0]) begin
                if (cnt > 0) check("b2b gap", 32'(cyc - last), 32'd3);
                ref_mem[0][8'(32 + cnt)] = 32'hC0DE_0000 + 32'(cnt);
                last = cyc;
                cnt++;
                if (cnt < 4) begin
                    addr[0]  = 32'h80 + 32'(4 * cnt);
                    wdata[0] = 32'hC0DE_0000 + 32'(cnt);
                end else begin
                    req[0] = 1'b0;
                end
            end
        end
        req[0] = 1'b0;
        check("b2b count", 32'(cnt), 32'd4);
        for (int i = 0; i < 4; i++) txn(0, 1'b0, 32'h80 + 32'(4 * i), 32'h0, 1'b0);

        // Reset during WAIT drops the pending store
        txn(0, 1'b1, 32'h40, 32'h1111_1111, 1'b0);
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'hA5A5_A5A5;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort ready", {31'd0, rdy[0]}, 32'd0);
        check("abort rdata", rdata[0], 32'd0);
        reset = 1'b0;
        for (int k = 0; k < N; k++) exp_rd[k] = 32'd0;
        txn(0, 1'b0, 32'h40, 32'h0, 1'b0);

        // LATENCY = 1
        txn(1, 1'b1, 32'h4, 32'h0000_AAAA, 1'b0);
        txn(1, 1'b0, 32'h4, 32'h0, 1'b0);
        txn(1, 1'b1, 32'h3FC, 32'h5555_0001, 1'b0);
        txn(1, 1'b0, 32'h3FC, 32'h0, 1'b0);
        txn(1, 1'b0, 32'h2, 32'h0, 1'b1);
        txn(1, 1'b0, 32'h4, 32'h0, 1'b0);
        // LATENCY = 3, BASE_ADDR = 0x100
        txn(2, 1'b1, 32'h100, 32'hFACE_0100, 1'b0);
        txn(2, 1'b0, 32'h100, 32'h0, 1'b0);
        txn(2, 1'b0, 32'hFC, 32'h0, 1'b1);
        txn(2, 1'b1, 32'h4FC, 32'hFACE_04FC, 1'b0);
        txn(2, 1'b0, 32'h4FC, 32'h0, 1'b0);
        txn(2, 1'b1, 32'h500, 32'h0BAD_0500, 1'b1);
        txn(2, 1'b0, 32'h100, 32'h0, 1'b0);
        // LATENCY = 15
        txn(3, 1'b1, 32'h8, 32'h0F0F_0F0F, 1'b0);
        txn(3, 1'b1, 32'h20, 32'h7777_2020, 1'b0);
        txn(3, 1'b0, 32'h8, 32'h0, 1'b0);
        txn(3, 1'b0, 32'h20, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
